// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the
// datapath enables, guards memory requests with a timeout, counts retired
// instructions and raises sticky error flags.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | load IR, PC <= PC+4 (held off while halt=1)
// DECODE | classify opcode; nop retires here, unsupported opcodes flag illegal
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory request held until mem_ready or timeout
// WB     | register write-back, retire
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             regwrite,
    output logic             alusrc,
    output logic             ssalu,
    output logic [1:0]       aluop,
    output logic             memread,
    output logic             memwrite,
    output logic             ssmemadr,
    output logic             ssmemwrite,
    output logic             memtoreg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_SS   = 7'b1110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    // Last wait count before a MEM request is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [6:0]         op_q;
    logic [2:0]         f3_q;
    logic [7:0]         wait_q;
    logic [CNT_W-1:0]   instret_q;
    logic               illegal_q, mem_err_q;
    logic               retire, set_illegal, set_mem_err, mem_exit;
    logic               br_ok, br_taken;

    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

    // Next-state and Moore-style control decode from state plus latched op.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        regwrite    = 1'b0;
        alusrc      = 1'b0;
        ssalu       = 1'b0;
        aluop       = 2'd0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        ssmemadr    = 1'b0;
        ssmemwrite  = 1'b0;
        memtoreg    = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_mem_err = 1'b0;
        mem_exit    = 1'b0;
        br_ok       = 1'b0;
        br_taken    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!halt) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // The IR was loaded on entry, so the live opcode is valid here.
                if (opcode == OP_NOP) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_R  || opcode == OP_ADDI || opcode == OP_LW ||
                             opcode == OP_SW || opcode == OP_SS   || opcode == OP_BR) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        aluop   = 2'd2;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alusrc  = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alusrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_SS: begin
                        ssalu   = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BR: begin
                        aluop = 2'd1;
                        case (f3_q)
                            3'b000: begin br_ok = 1'b1; br_taken = zero;        end
                            3'b100: begin br_ok = 1'b1; br_taken = neg;         end
                            3'b101: begin br_ok = 1'b1; br_taken = zero | ~neg; end
                            default: begin br_ok = 1'b0; br_taken = 1'b0;       end
                        endcase
                        pc_write    = br_ok & br_taken;
                        pc_src      = br_ok & br_taken;
                        retire      = br_ok;
                        set_illegal = ~br_ok;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Request is held steady for the whole MEM stay.
                case (op_q)
                    OP_LW: begin
                        memread = 1'b1;
                        alusrc  = 1'b1;
                    end
                    OP_SW: begin
                        memwrite = 1'b1;
                        alusrc   = 1'b1;
                    end
                    OP_SS: begin
                        memwrite   = 1'b1;
                        ssmemadr   = 1'b1;
                        ssmemwrite = 1'b1;
                        ssalu      = 1'b1;
                    end
                    default: ;
                endcase
                // mem_ready takes priority over a coincident timeout.
                if (mem_ready) begin
                    mem_exit = 1'b1;
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    mem_exit    = 1'b1;
                    set_mem_err = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = (op_q == OP_LW);
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // While reset is held, no enable may reach the datapath.
        if (!rst) begin
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            ir_write    = 1'b0;
            regwrite    = 1'b0;
            alusrc      = 1'b0;
            ssalu       = 1'b0;
            aluop       = 2'd0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            ssmemadr    = 1'b0;
            ssmemwrite  = 1'b0;
            memtoreg    = 1'b0;
            retire      = 1'b0;
            set_illegal = 1'b0;
            set_mem_err = 1'b0;
        end
    end

    // State register, op latch, MEM wait counter, retire counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            f3_q      <= 3'd0;
            wait_q    <= 8'd0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
            end
            if (state_q == S_MEM && !mem_exit) begin
                wait_q <= wait_q + 8'd1;
            end else begin
                wait_q <= 8'd0;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_mem_err) begin
                mem_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_mc_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             halt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero, neg, mem_ready;
    logic             pc_write, pc_src, ir_write, regwrite, alusrc, ssalu;
    logic [1:0]       aluop;
    logic             memread, memwrite, ssmemadr, ssmemwrite, memtoreg;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
    logic             illegal, mem_err;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    // {pc_write, pc_src, ir_write, regwrite, alusrc, ssalu, aluop, memread,
    //  memwrite, ssmemadr, ssmemwrite, memtoreg}
    logic [12:0] ctl;
    assign ctl = {pc_write, pc_src, ir_write, regwrite, alusrc, ssalu, aluop,
                  memread, memwrite, ssmemadr, ssmemwrite, memtoreg};

    localparam logic [12:0] C_NONE   = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_FETCH  = 13'b1_0_1_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_ALUIMM = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
    localparam logic [12:0] C_R_EX   = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
    localparam logic [12:0] C_WB     = 13'b0_0_0_1_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_WB_LW  = 13'b0_0_0_1_0_0_00_0_0_0_0_1;
    localparam logic [12:0] C_LW_MEM = 13'b0_0_0_0_1_0_00_1_0_0_0_0;
    localparam logic [12:0] C_SW_MEM = 13'b0_0_0_0_1_0_00_0_1_0_0_0;
    localparam logic [12:0] C_SS_EX  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
    localparam logic [12:0] C_SS_MEM = 13'b0_0_0_0_0_1_00_0_1_1_1_0;
    localparam logic [12:0] C_BR_NT  = 13'b0_0_0_0_0_0_01_0_0_0_0_0;
    localparam logic [12:0] C_BR_T   = 13'b1_1_0_0_0_0_01_0_0_0_0_0;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_SS   = 7'b1110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    mc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .neg        (neg),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .regwrite   (regwrite),
        .alusrc     (alusrc),
        .ssalu      (ssalu),
        .aluop      (aluop),
        .memread    (memread),
        .memwrite   (memwrite),
        .ssmemadr   (ssmemadr),
        .ssmemwrite (ssmemwrite),
        .memtoreg   (memtoreg),
        .state      (state),
        .instret    (instret),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; halt = 1'b0; opcode = OP_ADDI; funct3 = 3'd0;
        zero = 1'b0; neg = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset state: got %0d exp 0", state); end
            checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL reset ctl: got %b exp %b", ctl, C_NONE); end
        end
        checks++; if (instret !== '0) begin errors++; $display("FAIL reset instret: got %0d exp 0", instret); end
        checks++; if ({illegal, mem_err} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b exp 00", {illegal, mem_err}); end
    endtask

    task automatic test_halt_addi();
        logic [2:0]  st [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        logic [12:0] cv [8] = '{C_NONE, C_NONE, C_NONE, C_FETCH, C_NONE, C_ALUIMM, C_WB, C_NONE};
        logic        hl [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = OP_ADDI; funct3 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rst = 1'b1; halt = hl[i]; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL halt_addi state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL halt_addi ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        exp_instret = 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL halt_addi instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_r_type();
        logic [2:0]  st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        logic [12:0] cv [5] = '{C_FETCH, C_NONE, C_R_EX, C_WB, C_NONE};
        opcode = OP_R; funct3 = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL r_type state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL r_type ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL r_type instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_lw_wait();
        logic [2:0]  st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        logic [12:0] cv [8] = '{C_FETCH, C_NONE, C_ALUIMM, C_LW_MEM, C_LW_MEM, C_LW_MEM, C_WB_LW, C_NONE};
        logic        rd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = OP_LW; funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; mem_ready = rd[i]; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL lw state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL lw ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lw instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_branches();
        logic [2:0]  f3 [3] = '{3'b000, 3'b101, 3'b100};
        logic        zf [3] = '{1'b1, 1'b0, 1'b0};
        logic        nf [3] = '{1'b0, 1'b1, 1'b1};
        logic [12:0] ex [3] = '{C_BR_T, C_BR_NT, C_BR_T};
        logic [2:0]  st [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [12:0] cv [4];
        opcode = OP_BR;
        for (int b = 0; b < 3; b++) begin
            funct3 = f3[b]; zero = zf[b]; neg = nf[b];
            cv = '{C_FETCH, C_NONE, ex[b], C_NONE};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; #1;
                checks++; if (state !== st[i]) begin errors++; $display("FAIL branch%0d state cyc %0d: got %0d exp %0d", b, i, state, st[i]); end
                checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL branch%0d ctl cyc %0d: got %b exp %b", b, i, ctl, cv[i]); end
            end
            exp_instret = exp_instret + 1;
            checks++; if (instret !== exp_instret) begin errors++; $display("FAIL branch%0d instret: got %0d exp %0d", b, instret, exp_instret); end
        end
        zero = 1'b0; neg = 1'b0;
    endtask

    task automatic test_ss();
        logic [2:0]  st [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [12:0] cv [5] = '{C_FETCH, C_NONE, C_SS_EX, C_SS_MEM, C_NONE};
        opcode = OP_SS; funct3 = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; mem_ready = 1'b1; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL ss state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL ss ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        mem_ready = 1'b0;
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL ss instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    // Ready arrives in the same cycle the wait counter hits its limit.
    task automatic test_sw_ready_at_limit();
        logic [2:0]  st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        logic [12:0] cv [8] = '{C_FETCH, C_NONE, C_ALUIMM, C_SW_MEM, C_SW_MEM, C_SW_MEM, C_SW_MEM, C_NONE};
        logic        rd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_SW; funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; mem_ready = rd[i]; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_limit state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL sw_limit ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL sw_limit instret: got %0d exp %0d", instret, exp_instret); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL sw_limit mem_err: got %b exp 0", mem_err); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  st [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        logic [12:0] cv [5] = '{C_FETCH, C_NONE, C_FETCH, C_NONE, C_NONE};
        logic        hl [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_NOP; funct3 = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); halt = hl[i]; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL b2b_nop state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL b2b_nop ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        exp_instret = exp_instret + 2;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_nop instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_sw_timeout();
        logic [2:0]  st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        logic [12:0] cv [8] = '{C_FETCH, C_NONE, C_ALUIMM, C_SW_MEM, C_SW_MEM, C_SW_MEM, C_SW_MEM, C_NONE};
        opcode = OP_SW; funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; mem_ready = 1'b0; #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_timeout state cyc %0d: got %0d exp %0d", i, state, st[i]); end
            checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL sw_timeout ctl cyc %0d: got %b exp %b", i, ctl, cv[i]); end
        end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL sw_timeout mem_err: got %b exp 1", mem_err); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL sw_timeout instret: got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_illegal();
        logic [2:0]  st3 [3] = '{3'd0, 3'd1, 3'd0};
        logic [12:0] cv3 [3] = '{C_FETCH, C_NONE, C_NONE};
        logic [2:0]  st4 [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [12:0] cv4 [4] = '{C_FETCH, C_NONE, C_BR_NT, C_NONE};
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal pre: got %b exp 0", illegal); end
        opcode = OP_BAD; funct3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; #1;
            checks++; if (state !== st3[i]) begin errors++; $display("FAIL bad_op state cyc %0d: got %0d exp %0d", i, state, st3[i]); end
            checks++; if (ctl !== cv3[i]) begin errors++; $display("FAIL bad_op ctl cyc %0d: got %b exp %b", i, ctl, cv3[i]); end
        end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL bad_op illegal: got %b exp 1", illegal); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL bad_op instret: got %0d exp %0d", instret, exp_instret); end
        // Branch with unsupported funct3 and a true zero flag must not redirect.
        opcode = OP_BR; funct3 = 3'b010; zero = 1'b1; neg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; #1;
            checks++; if (state !== st4[i]) begin errors++; $display("FAIL bad_br state cyc %0d: got %0d exp %0d", i, state, st4[i]); end
            checks++; if (ctl !== cv4[i]) begin errors++; $display("FAIL bad_br ctl cyc %0d: got %b exp %b", i, ctl, cv4[i]); end
        end
        zero = 1'b0; neg = 1'b0;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL bad_br instret: got %0d exp %0d", instret, exp_instret); end
        opcode = OP_NOP; funct3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); halt = (i == 0) ? 1'b0 : 1'b1; #1;
            checks++; if (state !== st3[i]) begin errors++; $display("FAIL nop state cyc %0d: got %0d exp %0d", i, state, st3[i]); end
            checks++; if (ctl !== cv3[i]) begin errors++; $display("FAIL nop ctl cyc %0d: got %b exp %b", i, ctl, cv3[i]); end
        end
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL nop instret: got %0d exp %0d", instret, exp_instret); end
        checks++; if ({illegal, mem_err} !== 2'b11) begin errors++; $display("FAIL sticky flags: got %b exp 11", {illegal, mem_err}); end
    endtask

    task automatic test_reset_mid_instr();
        opcode = OP_ADDI; funct3 = 3'd0;
        @(negedge clk); halt = 1'b0; #1;
        @(negedge clk); halt = 1'b1; #1;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL rst_mid pre state: got %0d exp 1", state); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rst_mid ctl in EXEC: got %b exp %b", ctl, C_NONE); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_mid state: got %0d exp 0", state); end
        checks++; if (instret !== '0) begin errors++; $display("FAIL rst_mid instret: got %0d exp 0", instret); end
        checks++; if ({illegal, mem_err} !== 2'b00) begin errors++; $display("FAIL rst_mid flags: got %b exp 00", {illegal, mem_err}); end
        exp_instret = '0;
    endtask

    initial begin
        test_reset();
        test_halt_addi();
        test_r_type();
        test_lw_wait();
        test_branches();
        test_ss();
        test_sw_ready_at_limit();
        test_back_to_back();
        test_sw_timeout();
        test_illegal();
        test_reset_mid_instr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32 subset datapath: R-type, addi, lw, sw, beq/blt/bge, the custom ss instruction, and nop (all-zero word).
- Replaces the single-cycle ControlUnit.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables.
- Holds memory requests until the data memory handshakes, with a timeout guard.
- Counts retired instructions and flags illegal or aborted instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles a MEM request waits for mem_ready before abort (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
halt  in  1  hold in FETCH without issuing; sampled only in FETCH
opcode  in  7  inst[6:0] from instruction register
funct3  in  3  inst[14:12] from instruction register
zero  in  1  ALU zero flag
neg  in  1  ALU A<B flag
mem_ready  in  1  data memory completion strobe
pc_write  out  1  PC register load enable
pc_src  out  1  0: PC+4; 1: branch target
ir_write  out  1  instruction register load enable
regwrite  out  1  register bank write enable
alusrc  out  1  ALU B = immediate
ssalu  out  1  ALU A = immediate (ss)
aluop  out  2  0 add, 1 sub, 2 funct-decoded
memread  out  1  data memory read request
memwrite  out  1  data memory write request
ssmemadr  out  1  memory address from data1 (ss)
ssmemwrite  out  1  memory write data from aluout (ss)
memtoreg  out  1  writeback selects readdata
state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
instret  out  CNT_W  retired-instruction count
illegal  out  1  sticky: unsupported opcode/funct3 seen
mem_err  out  1  sticky: MEM timeout abort occurred

Behaviour:
Reset (rst=0 at posedge):
- state=FETCH; instret=0; illegal=0; mem_err=0; wait counter=0; latched op=0.
- All control outputs are 0 while rst=0.

Latching:
- opcode/funct3 are latched internally on DECODE entry.
- Outputs are Moore-decoded from state plus the latched op.

FETCH:
- halt=1: all outputs 0, stay in FETCH.
- halt=0: ir_write=1, pc_write=1, pc_src=0; go to DECODE.

DECODE:
- No enables asserted.
- opcode 0000000 (nop): instret++, go to FETCH.
- Supported opcode: go to EXEC.
- Otherwise: illegal<=1, no retire, go to FETCH.

EXEC:
- R (0110011): aluop=2 -> WB.
- addi (0010011): alusrc=1, aluop=0 -> WB.
- lw (0000011) / sw (0100011): alusrc=1, aluop=0 -> MEM.
- ss (1110011): ssalu=1, aluop=0 -> MEM.
- Branch (1100011): aluop=1. Taken condition by funct3:
  - 000 (beq): zero.
  - 100 (blt): neg.
  - 101 (bge): zero | ~neg.
  - If taken: pc_write=1, pc_src=1.
  - instret++, go to FETCH.
  - Any other funct3: illegal<=1, no PC write, no retire, go to FETCH.

MEM:
- Request outputs held constant every MEM cycle until exit:
  - lw: memread=1, alusrc=1.
  - sw: memwrite=1, alusrc=1.
  - ss: memwrite=1, ssmemadr=1, ssmemwrite=1, ssalu=1.
- Wait counter increments each MEM cycle without mem_ready.
- mem_ready=1 exit: lw -> WB; sw/ss -> instret++, FETCH.
- Timeout: counter reaches MEM_TIMEOUT-1 with mem_ready=0 -> mem_err<=1, no retire, FETCH.
- mem_ready in the same cycle as timeout: completes normally (ready wins).
- Counter clears on MEM exit.

WB:
- regwrite=1; memtoreg=1 for lw, else 0.
- instret++, go to FETCH.

Latency with zero memory wait:
- nop 2, branch 3, R/addi 4, sw/ss 4, lw 5 cycles.
- Each mem_ready wait cycle adds 1.

Counters and flags:
- instret wraps modulo 2^CNT_W.
- illegal and mem_err clear only on reset.
- Reset mid-instruction: aborts immediately; no retire; no write enable in the reset cycle.

Test Plan:
- Reset, halt=1 for 3 cycles, then halt=0 with addi (0010011) -> state 0,0,0,0,1,2,4,0; ir_write only in the first released FETCH cycle; regwrite=1 only in WB; instret=1.
- lw, mem_ready low for 2 MEM cycles then high -> MEM lasts 3 cycles with memread=1 and alusrc=1 held; WB has memtoreg=1; 7 cycles total.
- Branches:
  - beq, zero=1 -> EXEC pc_write=1, pc_src=1.
  - bge, neg=1, zero=0 -> no pc_write.
  - blt, neg=1 -> taken.
  - Each retires once.
- ss, mem_ready=1 on first MEM cycle -> memwrite=ssmemadr=ssmemwrite=ssalu=1 for exactly 1 cycle; instret+1; no regwrite.
- sw with mem_ready never asserted, MEM_TIMEOUT=4 -> 4 MEM cycles, mem_err=1, instret unchanged, back to FETCH.
- opcode 1111111, and branch with funct3=010 -> illegal=1, instret unchanged; a subsequent nop retires in 2 cycles.
